picorv32_cmd_rsp_bridge: RTL and testbench
==========================================

// Module: picorv32_cmd_rsp_bridge
// PURPOSE
//  Next-generation bridge from the picorv32 native memory interface to the SoC cmd/rsp bus.
//  Adds a posted-write buffer, strict read-after-write ordering, held read commands and an optional read timeout.
//  Sits between u_picorv32 and the SoC interconnect; one outstanding read at a time.
// PARAMETERS
//  ADDR_WIDTH      32           address width, cpu and bus side
//  DATA_WIDTH      32           data width; byte-enable width = DATA_WIDTH/8
//  WBUF_DEPTH      4            posted-write FIFO entries; power of 2, >=2
//  POSTED_WRITES   1            1: writes acked on buffer push; 0: acked on bus cmd handshake
//  TIMEOUT_CYCLES  0            read-response timeout in cycles; 0 disables
//  TIMEOUT_RDATA   32'hDEADBEEF rdata returned to the cpu on timeout
// PORTS
//  clk            in   1      clock
//  reset_         in   1      asynchronous reset, active low
//  cpu_valid      in   1      cpu request; held until cpu_ready
//  cpu_instr      in   1      instruction fetch (treated as a read)
//  cpu_addr       in   AW     request address
//  cpu_wdata      in   DW     write data
//  cpu_wstrb      in   DW/8   byte strobes; nonzero = write
//  cpu_ready      out  1      one-cycle request completion
//  cpu_rdata      out  DW     read data, valid while cpu_ready is high on a read
//  mem_cmd_valid  out  1      bus command valid
//  mem_cmd_ready  in   1      bus command accept
//  mem_cmd_instr  out  1      command is an instruction fetch
//  mem_cmd_wr     out  1      command is a write
//  mem_cmd_addr   out  AW     command address
//  mem_cmd_wdata  out  DW     command write data
//  mem_cmd_be     out  DW/8   command byte enables
//  mem_rsp_ready  in   1      read response valid (single cycle)
//  mem_rsp_rdata  in   DW     read response data
//  wbuf_level     out  $clog2(WBUF_DEPTH+1)  posted-write entries currently held
//  rd_timeout     out  1      one-cycle pulse when a read times out
//  rsp_unexpected out  1      one-cycle pulse on mem_rsp_ready outside RD_RSP
// BEHAVIOUR
//  Reset (async assert): FSM=IDLE, FIFO empty, all outputs 0; buffered writes are discarded.
//  mem_cmd_* outputs come from registers and the FIFO head only; there is no combinational path from cpu_*.
//  A command is held stable until mem_cmd_valid && mem_cmd_ready.
//  Posted write (POSTED_WRITES=1):
//  - In IDLE with cpu_valid && wstrb!=0 && !full: push {addr,wdata,be}; cpu_ready=1 in the same cycle.
//  - When full: no push, even if a pop occurs in that cycle; cpu waits.
//  Drain: whenever the FIFO is non-empty and FSM is not in RD_CMD/RD_RSP, present the head with mem_cmd_wr=1.
//  - Pop on handshake; wbuf_level updates the next cycle.
//  Non-posted write (POSTED_WRITES=0): FSM IDLE->WR_CMD; cpu_ready=1 in the cycle of the cmd handshake.
//  Read FSM: IDLE -> DRAIN (FIFO non-empty) or RD_CMD (FIFO empty).
//  - DRAIN -> RD_CMD once the FIFO is empty.
//  - RD_CMD: mem_cmd_valid=1, wr=0, instr=cpu_instr; -> RD_RSP on handshake.
//  - mem_rsp_ready is sampled only in RD_RSP, i.e. strictly after the cmd handshake cycle.
//  - RD_RSP: on mem_rsp_ready, cpu_ready=1 and cpu_rdata=mem_rsp_rdata (combinational, same cycle); -> IDLE.
//  Timeout: a counter clears on entry to RD_RSP.
//  - At TIMEOUT_CYCLES with no response: cpu_ready=1, rdata=TIMEOUT_RDATA, rd_timeout=1; -> IDLE.
//  - A response arriving in the expiry cycle wins over the timeout.
//  Any mem_rsp_ready outside RD_RSP is dropped and pulses rsp_unexpected.
//  Reads never bypass buffered writes, so there is no read-after-write hazard.
//  Writes pushed while a read is pending are impossible: the cpu blocks on the read.
// STRUCTURE
//  Include soc_bus_defs.vh: FSM state localparams (IDLE, DRAIN, RD_CMD, RD_RSP, WR_CMD) and cmd field widths.
//  Sub-module bridge_wbuf: synchronous FIFO, depth WBUF_DEPTH, width AW+DW+DW/8.
//  - Pointers carry one extra wrap bit; outputs full, empty, level.
// TESTING
//  Write 0x10=0xA5A5A5A5, mem_cmd_ready=1 -> cpu_ready same cycle; bus write 1 cycle later, be=4'hF.
//  Five writes, mem_cmd_ready=0 -> 4 acked, level=4, 5th stalls; first handshake frees a slot; 5th acked the next cycle.
//  Write then read 0x10 with ready held 0 for 3 cycles -> read cmd issued only after the write pop; rdata returned.
//  Read with mem_cmd_ready low 5 cycles -> mem_cmd_valid/addr held stable throughout; no early response accepted.
//  TIMEOUT_CYCLES=8, no rsp -> cpu_ready with 0xDEADBEEF after 8 cycles in RD_RSP; late rsp pulses rsp_unexpected.
//  reset_ low mid-drain with 3 entries -> outputs 0 immediately, level=0, next read goes straight to RD_CMD.

Source files
------------

// File: rtl/picorv32_cmd_rsp_bridge_pkg.sv
// Shared types and helpers for the picorv32 cmd/rsp bridge.
package picorv32_cmd_rsp_bridge_pkg;

  // Bridge control states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_RD_CMD = 3'd2,
    ST_RD_RSP = 3'd3,
    ST_WR_CMD = 3'd4
  } state_e;

  // Byte-enable width for a given data width
  function automatic int unsigned be_width(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/picorv32_cmd_rsp_bridge_if.sv
// Bus bundles for the bridge.
//   cpu side: picorv32 native memory interface (master = cpu, slave = bridge)
//   mem side: SoC cmd/rsp bus (master = bridge, slave = interconnect)
interface picorv32_cmd_rsp_bridge_cpu_if
  import picorv32_cmd_rsp_bridge_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned BW = be_width(DW);

  logic          cpu_valid;
  logic          cpu_instr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [BW-1:0] cpu_wstrb;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;

  modport master (output cpu_valid, cpu_instr, cpu_addr, cpu_wdata, cpu_wstrb,
                  input  cpu_ready, cpu_rdata);
  modport slave  (input  cpu_valid, cpu_instr, cpu_addr, cpu_wdata, cpu_wstrb,
                  output cpu_ready, cpu_rdata);
endinterface

interface picorv32_cmd_rsp_bridge_mem_if
  import picorv32_cmd_rsp_bridge_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned BW = be_width(DW);

  logic          mem_cmd_valid;
  logic          mem_cmd_ready;
  logic          mem_cmd_instr;
  logic          mem_cmd_wr;
  logic [AW-1:0] mem_cmd_addr;
  logic [DW-1:0] mem_cmd_wdata;
  logic [BW-1:0] mem_cmd_be;
  logic          mem_rsp_ready;
  logic [DW-1:0] mem_rsp_rdata;

  modport master (output mem_cmd_valid, mem_cmd_instr, mem_cmd_wr, mem_cmd_addr,
                         mem_cmd_wdata, mem_cmd_be,
                  input  mem_cmd_ready, mem_rsp_ready, mem_rsp_rdata);
  modport slave  (input  mem_cmd_valid, mem_cmd_instr, mem_cmd_wr, mem_cmd_addr,
                         mem_cmd_wdata, mem_cmd_be,
                  output mem_cmd_ready, mem_rsp_ready, mem_rsp_rdata);
endinterface

// File: rtl/picorv32_cmd_rsp_bridge_wbuf.sv
// Posted-write FIFO. Pointers carry an extra wrap bit to tell full from empty.
//   push/push_data : enqueue (ignored when full)
//   pop            : dequeue head (ignored when empty)
//   head           : current oldest entry
//   full/empty/level : occupancy status, updated the cycle after push/pop
module picorv32_cmd_rsp_bridge_wbuf #(
  parameter  int unsigned WIDTH = 68,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned PTRW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
    end
  end

  // Storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q[PW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign level = LW'(wr_ptr_q - rd_ptr_q);

endmodule

// File: rtl/picorv32_cmd_rsp_bridge.sv
// Bridge from the picorv32 native memory interface to the SoC cmd/rsp bus.
// Posted-write buffer, reads ordered behind buffered writes, one read outstanding,
// optional read-response timeout.
//   clk, reset_    : clock, async active-low reset
//   cpu            : picorv32 request side (slave modport)
//   mem            : SoC cmd/rsp side (master modport)
//   wbuf_level     : posted-write entries held
//   rd_timeout     : pulse when a read completes by timeout
//   rsp_unexpected : pulse on a response outside the read-response phase
module picorv32_cmd_rsp_bridge
  import picorv32_cmd_rsp_bridge_pkg::*;
#(
  parameter  int unsigned           ADDR_WIDTH     = 32,
  parameter  int unsigned           DATA_WIDTH     = 32,
  parameter  int unsigned           WBUF_DEPTH     = 4,
  parameter  int unsigned           POSTED_WRITES  = 1,
  parameter  int unsigned           TIMEOUT_CYCLES = 0,
  parameter  logic [DATA_WIDTH-1:0] TIMEOUT_RDATA  = 32'hDEADBEEF,
  localparam int unsigned           BE_WIDTH       = be_width(DATA_WIDTH),
  localparam int unsigned           LVL_WIDTH      = $clog2(WBUF_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_,
  picorv32_cmd_rsp_bridge_cpu_if.slave  cpu,
  picorv32_cmd_rsp_bridge_mem_if.master mem,
  output logic [LVL_WIDTH-1:0] wbuf_level,
  output logic                 rd_timeout,
  output logic                 rsp_unexpected
);
  localparam int unsigned FW = ADDR_WIDTH + DATA_WIDTH + BE_WIDTH;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_wdata_q;
  logic [BE_WIDTH-1:0]   cmd_be_q;
  logic                  cmd_instr_q;
  logic [TW-1:0]         tmo_cnt_q;

  logic          is_wr, tmo_hit, push_c, pop_c, capture_c, drain_c;
  logic          full, empty;
  logic [FW-1:0] head;

  assign is_wr   = (cpu.cpu_wstrb != '0);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  // Buffered writes go out only while no read is on the bus
  assign drain_c = !empty && ((state_q == ST_IDLE) || (state_q == ST_DRAIN));
  assign pop_c   = drain_c && mem.mem_cmd_ready;

  picorv32_cmd_rsp_bridge_wbuf #(
    .WIDTH (FW),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .reset_    (reset_),
    .push      (push_c),
    .push_data ({cpu.cpu_addr, cpu.cpu_wdata, cpu.cpu_wstrb}),
    .pop       (pop_c),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (wbuf_level)
  );

  // State, captured command and response-timeout counter
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_be_q    <= '0;
      cmd_instr_q <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture_c) begin
        cmd_addr_q  <= cpu.cpu_addr;
        cmd_wdata_q <= cpu.cpu_wdata;
        cmd_be_q    <= cpu.cpu_wstrb;
        cmd_instr_q <= cpu.cpu_instr;
      end
      tmo_cnt_q <= (state_q == ST_RD_RSP) ? tmo_cnt_q + TW'(1) : '0;
    end
  end

  // Next state, cpu completion and bus command selection
  always_comb begin
    state_d           = state_q;
    push_c            = 1'b0;
    capture_c         = 1'b0;
    cpu.cpu_ready     = 1'b0;
    cpu.cpu_rdata     = '0;
    rd_timeout        = 1'b0;
    mem.mem_cmd_valid = 1'b0;
    mem.mem_cmd_instr = 1'b0;
    mem.mem_cmd_wr    = 1'b0;
    mem.mem_cmd_addr  = '0;
    mem.mem_cmd_wdata = '0;
    mem.mem_cmd_be    = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpu.cpu_valid) begin
          if (is_wr) begin
            if (POSTED_WRITES != 0) begin
              // No push when full, even if the head pops this cycle
              if (!full) begin
                push_c        = 1'b1;
                cpu.cpu_ready = 1'b1;
              end
            end else begin
              capture_c = 1'b1;
              state_d   = ST_WR_CMD;
            end
          end else begin
            capture_c = 1'b1;
            state_d   = empty ? ST_RD_CMD : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (empty) state_d = ST_RD_CMD;
      end
      ST_RD_CMD: begin
        mem.mem_cmd_valid = 1'b1;
        mem.mem_cmd_instr = cmd_instr_q;
        mem.mem_cmd_addr  = cmd_addr_q;
        if (mem.mem_cmd_ready) state_d = ST_RD_RSP;
      end
      ST_RD_RSP: begin
        // A response in the expiry cycle takes priority over the timeout
        if (mem.mem_rsp_ready) begin
          cpu.cpu_ready = 1'b1;
          cpu.cpu_rdata = mem.mem_rsp_rdata;
          state_d       = ST_IDLE;
        end else if (tmo_hit) begin
          cpu.cpu_ready = 1'b1;
          cpu.cpu_rdata = TIMEOUT_RDATA;
          rd_timeout    = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_WR_CMD: begin
        mem.mem_cmd_valid = 1'b1;
        mem.mem_cmd_wr    = 1'b1;
        mem.mem_cmd_addr  = cmd_addr_q;
        mem.mem_cmd_wdata = cmd_wdata_q;
        mem.mem_cmd_be    = cmd_be_q;
        if (mem.mem_cmd_ready) begin
          cpu.cpu_ready = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (drain_c) begin
      mem.mem_cmd_valid = 1'b1;
      mem.mem_cmd_wr    = 1'b1;
      {mem.mem_cmd_addr, mem.mem_cmd_wdata, mem.mem_cmd_be} = head;
    end
  end

  assign rsp_unexpected = mem.mem_rsp_ready && (state_q != ST_RD_RSP);

endmodule

// File: tb/tb_picorv32_cmd_rsp_bridge.sv
// Scoreboard bench for picorv32_cmd_rsp_bridge: directed stimulus pushes expected
// bus commands and read data; a negedge monitor pops and compares on handshakes.
module tb_picorv32_cmd_rsp_bridge;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 3;

  typedef struct {
    logic        wr;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  logic clk = 1'b0;
  logic reset_;
  logic [LW-1:0] wbuf_level;
  logic rd_timeout, rsp_unexpected;

  always #5 clk = ~clk;

  picorv32_cmd_rsp_bridge_cpu_if #(.AW(AW), .DW(DW)) cpu_if ();
  picorv32_cmd_rsp_bridge_mem_if #(.AW(AW), .DW(DW)) mem_if ();

  picorv32_cmd_rsp_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .WBUF_DEPTH     (4),
    .POSTED_WRITES  (1),
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_RDATA  (32'hDEADBEEF)
  ) dut (
    .clk            (clk),
    .reset_         (reset_),
    .cpu            (cpu_if),
    .mem            (mem_if),
    .wbuf_level     (wbuf_level),
    .rd_timeout     (rd_timeout),
    .rsp_unexpected (rsp_unexpected)
  );

  int checks = 0;
  int errors = 0;
  cmd_t exp_cmd[$];
  logic [31:0] exp_rd[$];
  cmd_t mc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare every bus handshake and cpu read completion against the queues
  always @(negedge clk) begin
    if (reset_) begin
      if (mem_if.mem_cmd_valid && mem_if.mem_cmd_ready) begin
        if (exp_cmd.size() == 0) fail_now("cmd_extra");
        else begin
          mc = exp_cmd.pop_front();
          check("cmd_wr", 32'(mem_if.mem_cmd_wr), 32'(mc.wr));
          check("cmd_addr", mem_if.mem_cmd_addr, mc.addr);
          check("cmd_instr", 32'(mem_if.mem_cmd_instr), 32'(mc.instr));
          if (mc.wr) begin
            check("cmd_wdata", mem_if.mem_cmd_wdata, mc.wdata);
            check("cmd_be", 32'(mem_if.mem_cmd_be), 32'(mc.be));
          end
        end
      end
      if (cpu_if.cpu_ready) begin
        check("ready_with_valid", 32'(cpu_if.cpu_valid), 32'd1);
        if (cpu_if.cpu_valid && cpu_if.cpu_wstrb == 4'h0) begin
          if (exp_rd.size() == 0) fail_now("rd_extra");
          else check("cpu_rdata", cpu_if.cpu_rdata, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic ins);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d; c.be = be; c.instr = ins;
    exp_cmd.push_back(c);
  endtask

  task automatic cpu_req(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic ins);
    cpu_if.cpu_valid = 1'b1;
    cpu_if.cpu_addr  = a;
    cpu_if.cpu_wdata = d;
    cpu_if.cpu_wstrb = s;
    cpu_if.cpu_instr = ins;
  endtask

  // n = cycles without cpu_ready before completion; to = rd_timeout in that cycle
  task automatic wait_ready(input int max, output int n, output logic to);
    n = 0;
    to = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_if.cpu_ready) begin
        to = rd_timeout;
        break;
      end
      n++;
      if (n >= max) begin
        fail_now("cpu_ready_never");
        break;
      end
    end
    @(posedge clk); #1;
    cpu_if.cpu_valid = 1'b0;
  endtask

  // Respond to the next read handshake after 'delay' cycles in the response phase
  task automatic serve_read(input logic [31:0] data, input int delay);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(mem_if.mem_cmd_valid && mem_if.mem_cmd_ready && !mem_if.mem_cmd_wr) && k < 40);
    if (k >= 40) begin
      fail_now("read_cmd_never");
      return;
    end
    @(posedge clk); #1;
    repeat (delay) begin @(posedge clk); #1; end
    mem_if.mem_rsp_ready = 1'b1;
    mem_if.mem_rsp_rdata = data;
    @(posedge clk); #1;
    mem_if.mem_rsp_ready = 1'b0;
  endtask

  task automatic wait_drained();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((wbuf_level != 0 || mem_if.mem_cmd_valid) && k < 40);
    if (k >= 40) fail_now("drain_never");
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    logic to;
    logic [3:0] be_tab [5];
    be_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h8};

    reset_ = 1'b0;
    cpu_req(32'h0, 32'h0, 4'h0, 1'b0);
    cpu_if.cpu_valid     = 1'b0;
    mem_if.mem_cmd_ready = 1'b0;
    mem_if.mem_rsp_ready = 1'b0;
    mem_if.mem_rsp_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_valid", 32'(mem_if.mem_cmd_valid), 32'd0);
    check("rst_cpu_ready", 32'(cpu_if.cpu_ready), 32'd0);
    check("rst_level", 32'(wbuf_level), 32'd0);
    @(posedge clk); #1;
    reset_ = 1'b1;

    // Posted write acked in the request cycle, bus write the next cycle
    mem_if.mem_cmd_ready = 1'b1;
    push_cmd(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 1'b0);
    cpu_req(32'h10, 32'hA5A5A5A5, 4'hF, 1'b0);
    @(negedge clk);
    check("wr_ack_same_cycle", 32'(cpu_if.cpu_ready), 32'd1);
    check("wr_no_bus_same_cycle", 32'(mem_if.mem_cmd_valid), 32'd0);
    @(posedge clk); #1;
    cpu_if.cpu_valid = 1'b0;
    @(negedge clk);
    check("wr_bus_next_cycle", 32'(mem_if.mem_cmd_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("wr_level_after_pop", 32'(wbuf_level), 32'd0);
    @(posedge clk); #1;

    // Five writes against a stalled bus: four fit, the fifth waits for a slot
    mem_if.mem_cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd(1'b1, 32'h100 + 32'(4 * i), 32'h1000_0000 + 32'(i), be_tab[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      cpu_req(32'h100 + 32'(4 * i), 32'h1000_0000 + 32'(i), be_tab[i], 1'b0);
      wait_ready(5, n, to);
      check("posted_ack_latency", 32'(n), 32'd0);
    end
    cpu_req(32'h110, 32'h1000_0004, be_tab[4], 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("full_stall", 32'(cpu_if.cpu_ready), 32'd0);
      check("level_full", 32'(wbuf_level), 32'd4);
      @(posedge clk); #1;
    end
    mem_if.mem_cmd_ready = 1'b1;
    wait_ready(10, n, to);
    check("fifth_ack_after_pop", 32'(n), 32'd1);
    wait_drained();

    // Read behind a buffered write: read command only after the write pops
    mem_if.mem_cmd_ready = 1'b0;
    push_cmd(1'b1, 32'h10, 32'h12345678, 4'hF, 1'b0);
    cpu_req(32'h10, 32'h12345678, 4'hF, 1'b0);
    wait_ready(5, n, to);
    check("raw_wr_ack", 32'(n), 32'd0);
    push_cmd(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    exp_rd.push_back(32'h12345678);
    cpu_req(32'h10, 32'h0, 4'h0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("raw_head_is_write", 32'(mem_if.mem_cmd_wr), 32'd1);
      check("raw_no_early_ready", 32'(cpu_if.cpu_ready), 32'd0);
      @(posedge clk); #1;
    end
    mem_if.mem_cmd_ready = 1'b1;
    fork
      wait_ready(20, n, to);
      serve_read(32'h12345678, 0);
    join

    // Read command held stable against a stalled bus; early response dropped
    mem_if.mem_cmd_ready = 1'b0;
    push_cmd(1'b0, 32'h200, 32'h0, 4'h0, 1'b1);
    exp_rd.push_back(32'hCAFEF00D);
    cpu_req(32'h200, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    check("rd_idle_no_ready", 32'(cpu_if.cpu_ready), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      mem_if.mem_rsp_ready = (k == 2);
      mem_if.mem_rsp_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      check("hold_valid", 32'(mem_if.mem_cmd_valid), 32'd1);
      check("hold_addr", mem_if.mem_cmd_addr, 32'h200);
      check("hold_wr", 32'(mem_if.mem_cmd_wr), 32'd0);
      check("hold_instr", 32'(mem_if.mem_cmd_instr), 32'd1);
      check("early_rsp_flag", 32'(rsp_unexpected), (k == 2) ? 32'd1 : 32'd0);
      check("early_rsp_no_ready", 32'(cpu_if.cpu_ready), 32'd0);
      @(posedge clk); #1;
    end
    mem_if.mem_rsp_ready = 1'b0;
    mem_if.mem_cmd_ready = 1'b1;
    fork
      wait_ready(20, n, to);
      serve_read(32'hCAFEF00D, 1);
    join
    check("held_rd_latency", 32'(n), 32'd2);
    check("held_rd_no_timeout", 32'(to), 32'd0);

    // Timeout: ready with 0xDEADBEEF in the 8th response cycle; late rsp flagged
    push_cmd(1'b0, 32'h300, 32'h0, 4'h0, 1'b0);
    exp_rd.push_back(32'hDEADBEEF);
    cpu_req(32'h300, 32'h0, 4'h0, 1'b0);
    wait_ready(20, n, to);
    check("timeout_latency", 32'(n), 32'd9);
    check("timeout_pulse", 32'(to), 32'd1);
    mem_if.mem_rsp_ready = 1'b1;
    mem_if.mem_rsp_rdata = 32'h0BADF00D;
    @(negedge clk);
    check("late_rsp_flag", 32'(rsp_unexpected), 32'd1);
    check("late_rsp_no_ready", 32'(cpu_if.cpu_ready), 32'd0);
    @(posedge clk); #1;
    mem_if.mem_rsp_ready = 1'b0;

    // Response in the expiry cycle beats the timeout
    push_cmd(1'b0, 32'h304, 32'h0, 4'h0, 1'b0);
    exp_rd.push_back(32'h11223344);
    cpu_req(32'h304, 32'h0, 4'h0, 1'b0);
    fork
      wait_ready(20, n, to);
      serve_read(32'h11223344, 7);
    join
    check("expiry_rsp_latency", 32'(n), 32'd9);
    check("expiry_rsp_no_timeout", 32'(to), 32'd0);

    // Reset mid-drain discards buffered writes
    mem_if.mem_cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_req(32'h500 + 32'(4 * i), 32'h5000_0000 + 32'(i), 4'hF, 1'b0);
      wait_ready(5, n, to);
      check("rst_fill_ack", 32'(n), 32'd0);
    end
    @(negedge clk);
    check("rst_fill_level", 32'(wbuf_level), 32'd3);
    @(posedge clk); #1;
    reset_ = 1'b0;
    #1;
    check("rst_async_valid", 32'(mem_if.mem_cmd_valid), 32'd0);
    check("rst_async_addr", mem_if.mem_cmd_addr, 32'd0);
    check("rst_async_level", 32'(wbuf_level), 32'd0);
    @(posedge clk); #1;
    reset_ = 1'b1;
    mem_if.mem_cmd_ready = 1'b1;
    push_cmd(1'b0, 32'h400, 32'h0, 4'h0, 1'b0);
    exp_rd.push_back(32'h55AA55AA);
    cpu_req(32'h400, 32'h0, 4'h0, 1'b0);
    fork
      wait_ready(20, n, to);
      serve_read(32'h55AA55AA, 0);
    join
    check("post_rst_rd_latency", 32'(n), 32'd2);

    repeat (2) @(posedge clk);
    #1;
    check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
